// File: rtl/fetch_unit.sv
// Instruction-fetch control: drives the PC, issues req/ack reads to imem and registers IF/ID.
// One-entry hold buffer absorbs ID stalls; redirects are honoured even while a read is outstanding.
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_write,
  input  logic            stall_id,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] ifid_pc,
  output logic [31:0]     ifid_instr,
  output logic            ifid_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_buf_pc;
  logic [31:0]     r_buf_instr;
  logic [XLEN-1:0] r_drop_addr;
  logic [XLEN-1:0] r_ifid_pc;
  logic [31:0]     r_ifid_instr;
  logic            r_ifid_valid;

  logic w_flush;
  logic w_take_mem;
  logic w_take_buf;

  // A flush in the IDLE cycle is ignored: nothing has been fetched yet.
  assign w_flush    = flush && (r_state != S_IDLE);
  assign w_take_mem = (r_state == S_FETCH) && imem_ack && !stall_id && !flush;
  assign w_take_buf = (r_state == S_HOLD) && !stall_id && !flush;

  always_comb begin
    pc_write = 1'b0;
    pc_next  = pc_cur;
    if (w_flush) begin
      pc_write = 1'b1;
      pc_next  = redirect_pc;
    end else if (w_take_mem) begin
      pc_write = 1'b1;
      pc_next  = pc_cur + XLEN'(4);
    end else if (w_take_buf) begin
      pc_write = 1'b1;
      pc_next  = r_buf_pc + XLEN'(4);
    end
  end

  // The PC only advances on ack, so pc_cur is a stable address for the whole read.
  assign imem_req  = (r_state == S_FETCH) || (r_state == S_DROP);
  assign imem_addr = (r_state == S_DROP) ? r_drop_addr : pc_cur;

  assign ifid_pc    = r_ifid_pc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_valid = r_ifid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_buf_pc     <= '0;
      r_buf_instr  <= '0;
      r_drop_addr  <= '0;
      r_ifid_pc    <= RESET_PC;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ifid_instr <= NOP_INSTR;
          r_ifid_valid <= 1'b0;
          r_state      <= S_FETCH;
        end
        S_FETCH: begin
          if (flush) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
            r_buf_pc     <= '0;
            r_buf_instr  <= '0;
            if (!imem_ack) begin
              r_drop_addr <= pc_cur;
              r_state     <= S_DROP;
            end
          end else if (imem_ack) begin
            if (stall_id) begin
              r_buf_pc    <= pc_cur;
              r_buf_instr <= imem_rdata;
              r_state     <= S_HOLD;
            end else begin
              r_ifid_pc    <= pc_cur;
              r_ifid_instr <= imem_rdata;
              r_ifid_valid <= 1'b1;
            end
          end else if (!stall_id) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (flush) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
            r_buf_pc     <= '0;
            r_buf_instr  <= '0;
            r_state      <= S_FETCH;
          end else if (!stall_id) begin
            r_ifid_pc    <= r_buf_pc;
            r_ifid_instr <= r_buf_instr;
            r_ifid_valid <= 1'b1;
            r_state      <= S_FETCH;
          end
        end
        S_DROP: begin
          // Data returning here belongs to a squashed path and never reaches ID.
          r_ifid_instr <= NOP_INSTR;
          r_ifid_valid <= 1'b0;
          if (flush) begin
            r_buf_pc    <= '0;
            r_buf_instr <= '0;
          end
          if (imem_ack) r_state <= S_FETCH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized stall/flush/memory-latency stimulus against a transaction-level model,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_cur, pc_next, redirect_pc, imem_addr, imem_rdata, ifid_pc, ifid_instr;
  logic        pc_write, stall_id, flush, imem_req, imem_ack, ifid_valid;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .pc_next(pc_next), .pc_write(pc_write),
    .stall_id(stall_id), .flush(flush), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment: the PC register and a variable-latency memory.
  logic        sv_pw;
  logic [31:0] sv_pn;
  bit          in_flight;
  int          wait_cnt;
  logic [31:0] flight_addr;
  int          next_lat = 0;
  bit          force_ack = 0;

  // Model: delivered instructions, a pending stalled instruction, and whether the read in flight is doomed.
  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;
  bit          m_started;
  ent_t        m_buf[$];
  bit          m_junk;
  logic [31:0] m_junk_addr;
  logic [31:0] m_pc, m_instr;
  bit          m_vld;

  task automatic model_reset();
    m_started = 0; m_buf.delete(); m_junk = 0; m_junk_addr = '0;
    m_pc = '0; m_instr = NOP; m_vld = 0;
    in_flight = 0; wait_cnt = 0; sv_pw = 0; sv_pn = '0; pc_cur = '0;
    stall_id = 0; flush = 0; redirect_pc = '0; imem_ack = 0; imem_rdata = '0;
  endtask

  task automatic step(input logic s, input logic f, input logic [31:0] rp);
    bit          exp_req, exp_pw, deliver;
    logic [31:0] exp_addr, exp_pn;
    ent_t        d;
    @(negedge clk);
    if (sv_pw) pc_cur = sv_pn;
    stall_id = s; flush = f; redirect_pc = rp;
    #1;
    imem_ack = 0;
    if (imem_req) begin
      if (!in_flight) begin
        in_flight = 1;
        wait_cnt = (next_lat < 0) ? int'($urandom_range(0, 3)) : next_lat;
        flight_addr = imem_addr;
      end else begin
        chk("addr_stable", imem_addr, flight_addr);
      end
      imem_ack = (wait_cnt == 0);
    end else if (force_ack) begin
      imem_ack = 1;
    end
    imem_rdata = imem_addr ^ KEY;
    #1;
    exp_req  = m_started && (m_buf.size() == 0);
    exp_addr = m_junk ? m_junk_addr : pc_cur;
    deliver  = 0;
    d        = '0;
    if (m_started && !f && !s) begin
      if (m_buf.size() != 0) begin
        deliver = 1; d = m_buf[0];
      end else if (!m_junk && imem_ack) begin
        deliver = 1; d = ent_t'({pc_cur, pc_cur ^ KEY});
      end
    end
    exp_pw = m_started && (f || deliver);
    exp_pn = (m_started && f) ? rp : (deliver ? d.pc + 32'd4 : pc_cur);
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, exp_addr);
    chk("pc_write", pc_write, exp_pw);
    chk("pc_next", pc_next, exp_pn);
    chk("ifid_pc", ifid_pc, m_pc);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_valid", ifid_valid, m_vld);
    sv_pw = pc_write; sv_pn = pc_next;
    if (!m_started) begin
      m_started = 1; m_instr = NOP; m_vld = 0;
    end else if (f) begin
      if (exp_req && !imem_ack) begin
        if (!m_junk) begin m_junk = 1; m_junk_addr = pc_cur; end
      end else begin
        m_junk = 0;
      end
      m_buf.delete(); m_instr = NOP; m_vld = 0;
    end else if (deliver) begin
      m_pc = d.pc; m_instr = d.instr; m_vld = 1;
      if (m_buf.size() != 0) void'(m_buf.pop_front());
    end else if (m_buf.size() == 0) begin
      if (m_junk) begin
        m_instr = NOP; m_vld = 0;
        if (imem_ack) m_junk = 0;
      end else if (imem_ack) begin
        m_buf.push_back(ent_t'({pc_cur, pc_cur ^ KEY}));
      end else if (!s) begin
        m_instr = NOP; m_vld = 0;
      end
    end
    if (in_flight && imem_ack) in_flight = 0;
    else if (in_flight) wait_cnt--;
  endtask

  // Asynchronous reset mid-cycle; outputs must react before any clock edge.
  task automatic async_reset();
    #1 rst_n = 0;
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", ifid_valid, 1'b0);
    chk("rst_pc", ifid_pc, 32'h0);
    chk("rst_instr", ifid_instr, NOP);
    chk("rst_pw", pc_write, 1'b0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_pc", ifid_pc, 32'h0);
    chk("init_valid", ifid_valid, 1'b0);
    chk("init_pn", pc_next, pc_cur);
    #1 rst_n = 1;

    // Zero-wait stream, with a stray ack during the IDLE cycle.
    next_lat = 0;
    force_ack = 1;
    step(0, 0, 0);
    force_ack = 0;
    chk("idle_req", imem_req, 1'b0);
    chk("idle_pw", pc_write, 1'b0);
    step(0, 0, 0);
    chk("s1_pn", pc_next, 32'h4);
    chk("s1_valid", ifid_valid, 1'b0);
    step(0, 0, 0);
    chk("s2_pc", ifid_pc, 32'h0);
    chk("s2_instr", ifid_instr, 32'hA5A5A5A5);
    chk("s2_valid", ifid_valid, 1'b1);
    step(0, 0, 0);
    chk("s3_pc", ifid_pc, 32'h4);
    chk("s3_pn", pc_next, 32'hC);

    // Wait states at 0x10.
    step(0, 1, 32'h10);
    next_lat = 2;
    step(0, 0, 0);
    chk("w0_addr", imem_addr, 32'h10);
    chk("w0_valid", ifid_valid, 1'b0);
    step(0, 0, 0);
    chk("w1_addr", imem_addr, 32'h10);
    chk("w1_pw", pc_write, 1'b0);
    step(0, 0, 0);
    chk("w2_addr", imem_addr, 32'h10);
    chk("w2_pn", pc_next, 32'h14);
    next_lat = 0;
    step(0, 0, 0);
    chk("w3_pc", ifid_pc, 32'h10);
    chk("w3_instr", ifid_instr, 32'hA5A5A5B5);
    chk("w3_valid", ifid_valid, 1'b1);

    // Stall on the ack cycle at 0x20, held three cycles.
    step(0, 1, 32'h20);
    step(1, 0, 0);
    chk("h_pw", pc_write, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      chk("h_req", imem_req, 1'b0);
      chk("h_pw2", pc_write, 1'b0);
    end
    step(0, 0, 0);
    chk("h_rel_pn", pc_next, 32'h24);
    step(0, 0, 0);
    chk("h_pc", ifid_pc, 32'h20);
    chk("h_instr", ifid_instr, 32'hA5A5A585);

    // Flush while a read to 0x30 is outstanding.
    step(0, 1, 32'h30);
    next_lat = 3;
    step(0, 0, 0);
    chk("d_addr0", imem_addr, 32'h30);
    step(0, 1, 32'h100);
    chk("d_pn", pc_next, 32'h100);
    chk("d_pw", pc_write, 1'b1);
    step(0, 0, 0);
    chk("d_addr1", imem_addr, 32'h30);
    next_lat = 0;
    step(0, 0, 0);
    chk("d_ack_addr", imem_addr, 32'h30);
    chk("d_ack_valid", ifid_valid, 1'b0);
    step(0, 0, 0);
    chk("d_next_addr", imem_addr, 32'h100);

    // Flush and stall together while holding 0x40.
    step(0, 1, 32'h40);
    step(1, 0, 0);
    step(1, 1, 32'h200);
    chk("fs_pn", pc_next, 32'h200);
    step(0, 0, 0);
    chk("fs_addr", imem_addr, 32'h200);
    chk("fs_valid", ifid_valid, 1'b0);
    step(0, 0, 0);
    chk("fs_pc", ifid_pc, 32'h200);

    // PC wrap, then reset with a read outstanding.
    step(0, 1, 32'hFFFFFFFC);
    step(0, 0, 0);
    chk("wrap_pn", pc_next, 32'h0);
    step(0, 0, 0);
    chk("wrap_pc", ifid_pc, 32'hFFFFFFFC);
    next_lat = 3;
    step(0, 0, 0);
    async_reset();
    force_ack = 1;
    step(0, 0, 0);
    force_ack = 0;
    step(0, 0, 0);
    chk("post_rst_addr", imem_addr, 32'h0);

    // Randomized traffic.
    next_lat = -1;
    for (int i = 0; i < 4000; i++) begin
      logic s, f;
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 9) == 0);
      step(s, f, $urandom & 32'hFFFFFFFC);
      if ($urandom_range(0, 699) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
